// File: rtl/pipeline_control.sv
// -----------------------------------------------------------------------------
// pipeline_control
//
// Hazard and halt controller for a five-stage pipeline. It produces the
// enable/clear strobes for the PC and the four pipeline registers. It also
// tracks the halt sequence (RUN -> HALT_DRAIN -> HALTED) and keeps free-running
// cycle and stall counters.
//
// Ports
//   CLK              in   rising-edge clock
//   nRST             in   synchronous active-low reset
//   ihit             in   instruction fetch completes this cycle
//   dhit             in   data access completes this cycle
//   mem_dreq         in   memory-stage instruction reads or writes memory
//   ex_dmemREN       in   execute-stage instruction is a load
//   ex_wsel[4:0]     in   execute-stage destination register
//   id_rs[4:0]       in   decode-stage source rs (0 if unused)
//   id_rt[4:0]       in   decode-stage source rt (0 if unused)
//   id_jump          in   decode holds J/JAL/JR
//   id_halt          in   decode holds HALT
//   ex_branch_taken  in   execute resolved a taken branch
//   wb_halt          in   HALT has reached writeback
//   pc_en            out  PC update enable
//   fd_en / fd_zero  out  fetch/decode register enable / clear
//   de_en / de_zero  out  decode/exec register enable / clear
//   em_en            out  exec/mem register enable
//   mw_en            out  mem/writeback register enable
//   halt             out  processor halted (registered, sticky until reset)
//   cycle_count[31:0] out non-halted cycles since reset
//   stall_count[31:0] out freeze, load-use and fetch-miss cycles since reset
// -----------------------------------------------------------------------------
module pipeline_control (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ihit,
   input  logic        dhit,
   input  logic        mem_dreq,
   input  logic        ex_dmemREN,
   input  logic [4:0]  ex_wsel,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_jump,
   input  logic        id_halt,
   input  logic        ex_branch_taken,
   input  logic        wb_halt,
   output logic        pc_en,
   output logic        fd_en,
   output logic        fd_zero,
   output logic        de_en,
   output logic        de_zero,
   output logic        em_en,
   output logic        mw_en,
   output logic        halt,
   output logic [31:0] cycle_count,
   output logic [31:0] stall_count
);

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      HALT_DRAIN = 2'd1,
      HALTED     = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic        r_halt;
   logic [31:0] r_cycle_count;
   logic [31:0] r_stall_count;

   logic        w_freeze;
   logic        w_load_use;
   logic        w_stall;

   // A pending data access freezes the whole pipeline until it completes.
   assign w_freeze = mem_dreq & ~dhit;

   // Register 0 is never really written, so a load that targets it cannot
   // create a hazard.
   assign w_load_use = ex_dmemREN && (ex_wsel != 5'd0) &&
                       ((ex_wsel == id_rs) || (ex_wsel == id_rt));

   always_comb begin
      pc_en        = 1'b0;
      fd_en        = 1'b0;
      fd_zero      = 1'b0;
      de_en        = 1'b0;
      de_zero      = 1'b0;
      em_en        = 1'b0;
      mw_en        = 1'b0;
      w_stall      = 1'b0;
      w_state_next = r_state;

      case (r_state)
         RUN: begin
            if (w_freeze) begin
               w_stall = 1'b1;
            end else if (ex_branch_taken) begin
               // Flush both younger stages; a HALT in decode dies here too.
               pc_en   = 1'b1;
               fd_en   = 1'b1;
               fd_zero = 1'b1;
               de_en   = 1'b1;
               de_zero = 1'b1;
               em_en   = 1'b1;
               mw_en   = 1'b1;
            end else if (w_load_use) begin
               // Hold PC and fetch/decode; insert one bubble into execute.
               de_en   = 1'b1;
               de_zero = 1'b1;
               em_en   = 1'b1;
               mw_en   = 1'b1;
               w_stall = 1'b1;
            end else begin
               if (id_jump) begin
                  pc_en   = 1'b1;
                  fd_en   = 1'b1;
                  fd_zero = 1'b1;
                  de_en   = 1'b1;
                  em_en   = 1'b1;
                  mw_en   = 1'b1;
               end else if (!ihit) begin
                  fd_en   = 1'b1;
                  fd_zero = 1'b1;
                  de_en   = 1'b1;
                  em_en   = 1'b1;
                  mw_en   = 1'b1;
                  w_stall = 1'b1;
               end else begin
                  pc_en   = 1'b1;
                  fd_en   = 1'b1;
                  de_en   = 1'b1;
                  em_en   = 1'b1;
                  mw_en   = 1'b1;
               end
               // HALT may only proceed when decode is actually advancing.
               if (id_halt) begin
                  w_state_next = HALT_DRAIN;
               end
            end
         end

         HALT_DRAIN: begin
            // Stop fetching, feed bubbles behind the HALT until it retires.
            if (w_freeze) begin
               w_stall = 1'b1;
            end else begin
               fd_en   = 1'b1;
               fd_zero = 1'b1;
               de_en   = 1'b1;
               em_en   = 1'b1;
               mw_en   = 1'b1;
            end
            // Retirement of the HALT wins even during a freeze.
            if (wb_halt) begin
               w_state_next = HALTED;
            end
         end

         HALTED: begin
            w_state_next = HALTED;
         end

         default: begin
            w_state_next = RUN;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_state       <= RUN;
         r_halt        <= 1'b0;
         r_cycle_count <= 32'd0;
         r_stall_count <= 32'd0;
      end else begin
         r_state <= w_state_next;
         if (w_state_next == HALTED) begin
            r_halt <= 1'b1;
         end
         if (r_state != HALTED) begin
            r_cycle_count <= r_cycle_count + 32'd1;
            r_stall_count <= r_stall_count + {31'd0, w_stall};
         end
      end
   end

   assign halt        = r_halt;
   assign cycle_count = r_cycle_count;
   assign stall_count = r_stall_count;

endmodule

// File: tb/tb_pipeline_control.sv
// -----------------------------------------------------------------------------
// tb_pipeline_control
//
// Self-checking bench for pipeline_control. A behavioural model classifies each
// cycle into one of the decode rows and derives strobes, halt and counters from
// that. It is compared against the DUT every cycle. Directed sequences pin the
// model with literal values; a randomized phase then exercises the rest.
// -----------------------------------------------------------------------------
module tb_pipeline_control;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        ihit, dhit, mem_dreq, ex_dmemREN;
   logic [4:0]  ex_wsel, id_rs, id_rt;
   logic        id_jump, id_halt, ex_branch_taken, wb_halt;
   logic        pc_en, fd_en, fd_zero, de_en, de_zero, em_en, mw_en, halt;
   logic [31:0] cycle_count, stall_count;
   logic [6:0]  outs;

   pipeline_control dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dreq(mem_dreq),
      .ex_dmemREN(ex_dmemREN), .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt),
      .id_jump(id_jump), .id_halt(id_halt), .ex_branch_taken(ex_branch_taken),
      .wb_halt(wb_halt), .pc_en(pc_en), .fd_en(fd_en), .fd_zero(fd_zero),
      .de_en(de_en), .de_zero(de_zero), .em_en(em_en), .mw_en(mw_en),
      .halt(halt), .cycle_count(cycle_count), .stall_count(stall_count)
   );

   always #5 CLK = ~CLK;

   // Strobe vector order: {pc_en, fd_en, fd_zero, de_en, de_zero, em_en, mw_en}
   assign outs = {pc_en, fd_en, fd_zero, de_en, de_zero, em_en, mw_en};

   localparam int MR = 0;  // running
   localparam int MD = 1;  // draining toward halt
   localparam int MH = 2;  // halted

   int          n_tests = 0;
   int          n_fail  = 0;
   int          m_mode  = MR;
   logic        m_halt  = 1'b0;
   logic [31:0] m_cc    = 32'd0;
   logic [31:0] m_sc    = 32'd0;
   bit          m_valid = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Which decode row applies this cycle, judged straight from the rules.
   function automatic byte row_of();
      logic lu;
      lu = ex_dmemREN && (ex_wsel != 5'd0) && ((ex_wsel == id_rs) || (ex_wsel == id_rt));
      if (m_mode == MH)            return "H";
      if (mem_dreq && !dhit)       return "a";
      if (m_mode == MD)            return "D";
      if (ex_branch_taken)         return "b";
      if (lu)                      return "c";
      if (id_jump)                 return "d";
      if (!ihit)                   return "e";
      return "f";
   endfunction

   function automatic logic [6:0] row_outs(input byte r);
      case (r)
         "b":     return 7'b1111111;
         "c":     return 7'b0001111;
         "d":     return 7'b1111011;
         "e","D": return 7'b0111011;
         "f":     return 7'b1101011;
         default: return 7'b0000000;
      endcase
   endfunction

   // One clock cycle: inputs were set at the preceding falling edge.
   task automatic cycle();
      byte r;
      r = row_of();
      #2;
      if (m_valid) begin
         chk("outs",        {25'd0, outs},   {25'd0, row_outs(r)});
         chk("halt",        {31'd0, halt},   {31'd0, m_halt});
         chk("cycle_count", cycle_count,     m_cc);
         chk("stall_count", stall_count,     m_sc);
      end
      @(posedge CLK);
      if (!nRST) begin
         m_mode = MR;
         m_halt = 1'b0;
         m_cc   = 32'd0;
         m_sc   = 32'd0;
      end else begin
         if (m_mode != MH) begin
            m_cc = m_cc + 32'd1;
            if (r == "a" || r == "c" || r == "e") m_sc = m_sc + 32'd1;
         end
         if (m_mode == MR && id_halt && (r == "d" || r == "e" || r == "f")) m_mode = MD;
         else if (m_mode == MD && wb_halt) m_mode = MH;
         m_halt = (m_mode == MH);
      end
      m_valid = 1'b1;
      @(negedge CLK);
   endtask

   task automatic idle();
      nRST = 1'b1; ihit = 1'b1; dhit = 1'b0; mem_dreq = 1'b0; ex_dmemREN = 1'b0;
      ex_wsel = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_jump = 1'b0; id_halt = 1'b0;
      ex_branch_taken = 1'b0; wb_halt = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      nRST = 1'b0;
      @(negedge CLK);
      cycle();
      cycle();

      // Ten plain cycles after reset.
      idle();
      for (int i = 0; i < 10; i++) cycle();
      #1;
      chk("lit_run_outs", {25'd0, outs}, {25'd0, 7'b1101011});
      chk("lit_run_cc", cycle_count, 32'd10);
      chk("lit_run_sc", stall_count, 32'd0);

      // Load-use hazard.
      ex_dmemREN = 1'b1; ex_wsel = 5'd5; id_rt = 5'd5;
      #1;
      chk("lit_lu_outs", {25'd0, outs}, {25'd0, 7'b0001111});
      cycle();
      chk("lit_lu_sc", stall_count, 32'd1);

      // Same with destination r0: no hazard.
      ex_wsel = 5'd0;
      #1;
      chk("lit_r0_outs", {25'd0, outs}, {25'd0, 7'b1101011});
      cycle();
      chk("lit_r0_sc", stall_count, 32'd1);

      // Freeze dominates a taken branch for three cycles, then branch flush.
      idle();
      mem_dreq = 1'b1; dhit = 1'b0; ex_branch_taken = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("lit_frz_outs", {25'd0, outs}, 32'd0);
         cycle();
      end
      chk("lit_frz_sc", stall_count, 32'd4);
      dhit = 1'b1;
      #1;
      chk("lit_br_outs", {25'd0, outs}, {25'd0, 7'b1111111});
      cycle();
      chk("lit_br_cc", cycle_count, 32'd16);

      // Jump with a fetch miss: jump row wins, no stall counted.
      idle();
      id_jump = 1'b1; ihit = 1'b0;
      #1;
      chk("lit_jmp_outs", {25'd0, outs}, {25'd0, 7'b1111011});
      cycle();
      chk("lit_jmp_sc", stall_count, 32'd4);

      // Halt sequence.
      idle();
      id_halt = 1'b1;
      cycle();
      idle();
      #1;
      chk("lit_drain_outs", {25'd0, outs}, {25'd0, 7'b0111011});
      cycle();
      wb_halt = 1'b1;
      cycle();
      idle();
      chk("lit_halt", {31'd0, halt}, 32'd1);
      chk("lit_halt_cc", cycle_count, 32'd20);
      for (int i = 0; i < 3; i++) begin
         ex_branch_taken = 1'($urandom_range(0, 1));
         ihit = 1'($urandom_range(0, 1));
         cycle();
      end
      chk("lit_halted_outs", {25'd0, outs}, 32'd0);
      chk("lit_halted_cc", cycle_count, 32'd20);

      // Reset out of HALTED.
      idle();
      nRST = 1'b0;
      cycle();
      idle();
      chk("lit_rst_halt", {31'd0, halt}, 32'd0);
      chk("lit_rst_cc", cycle_count, 32'd0);
      chk("lit_rst_sc", stall_count, 32'd0);

      // Counter wrap.
      force dut.r_cycle_count = 32'hFFFF_FFFF;
      #1;
      release dut.r_cycle_count;
      m_cc = 32'hFFFF_FFFF;
      cycle();
      chk("lit_wrap_cc", cycle_count, 32'd0);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 2000; i++) begin
         nRST            = ($urandom_range(0, 99) >= 2);
         ihit            = ($urandom_range(0, 99) < 80);
         dhit            = ($urandom_range(0, 99) < 70);
         mem_dreq        = ($urandom_range(0, 99) < 30);
         ex_dmemREN      = ($urandom_range(0, 99) < 30);
         ex_wsel         = 5'($urandom_range(0, 3));
         id_rs           = 5'($urandom_range(0, 3));
         id_rt           = 5'($urandom_range(0, 3));
         id_jump         = ($urandom_range(0, 99) < 15);
         id_halt         = ($urandom_range(0, 99) < 8);
         ex_branch_taken = ($urandom_range(0, 99) < 10);
         wb_halt         = ($urandom_range(0, 99) < 25);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pipeline_control.md
PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: CLK  in  1  rising-edge clock; nRST  in  1  synchronous active-low reset, sampled on the CLK rising edge.
REQ-002 Inputs SHALL be:
- ihit  in  1  instruction fetch completes this cycle
- dhit  in  1  data access completes this cycle
- mem_dreq  in  1  memory-stage instruction has dmemREN or dmemWEN set
- ex_dmemREN  in  1  execute-stage instruction is a load
- ex_wsel  in  5  execute-stage destination register
- id_rs  in  5  decode-stage source register rs (0 if unused)
- id_rt  in  5  decode-stage source register rt (0 if unused)
- id_jump  in  1  decode has a jump (J/JAL/JR)
- id_halt  in  1  decode holds HALT
- ex_branch_taken  in  1  execute resolved a taken branch
- wb_halt  in  1  HALT is in writeback
REQ-003 Outputs SHALL be:
- pc_en  out  1  PC update enable
- fd_en  out  1  fetch/decode register enable
- fd_zero  out  1  fetch/decode register clear
- de_en  out  1  decode/exec register enable
- de_zero  out  1  decode/exec register clear
- em_en  out  1  exec/mem register enable
- mw_en  out  1  mem/writeback register enable
- halt  out  1  processor halted, sticky
- cycle_count  out  32  cycles counted since reset
- stall_count  out  32  stall and bubble cycles counted since reset

Function
REQ-004 The FSM SHALL have the states RUN, HALT_DRAIN and HALTED, held in a register.
REQ-005 The *_en and *_zero outputs SHALL be combinational from state and inputs; halt and both counters SHALL be registered.
REQ-006 A *_zero output SHALL assert only while its matching *_en is 1.
REQ-007 load_use SHALL be defined as: ex_dmemREN=1, ex_wsel!=0, and ex_wsel equals id_rs or id_rt.
REQ-008 In RUN, exactly one of the following rows SHALL apply, first match wins:
(a) mem_dreq=1 and dhit=0: all *_en=0, all *_zero=0 (full freeze).
(b) ex_branch_taken=1: pc_en=1, fd_en=fd_zero=1, de_en=de_zero=1, em_en=mw_en=1.
(c) load_use: pc_en=0, fd_en=0, de_en=de_zero=1, em_en=mw_en=1 (one bubble).
(d) id_jump=1: pc_en=1, fd_en=fd_zero=1, de_en=1, em_en=mw_en=1.
(e) ihit=0: pc_en=0, fd_en=fd_zero=1, de_en=em_en=mw_en=1.
(f) otherwise: all *_en=1, all *_zero=0.
REQ-009 In RUN, the FSM SHALL go to HALT_DRAIN when id_halt=1 and neither row (a), (b) nor (c) applies; otherwise it SHALL stay in RUN.
REQ-010 In HALT_DRAIN, row (a) SHALL apply when its condition holds; otherwise pc_en=0, fd_en=fd_zero=1, de_en=em_en=mw_en=1.
REQ-011 In HALT_DRAIN, the FSM SHALL go to HALTED on the edge where wb_halt=1.
REQ-012 HALTED SHALL be absorbing until reset: all *_en=0, all *_zero=0, halt=1 from the first HALTED cycle.
REQ-013 cycle_count SHALL increment by 1 every non-HALTED cycle and wrap modulo 2^32.
REQ-014 stall_count SHALL increment by 1 in every non-HALTED cycle where row (a), (c) or (e) applies, and SHALL wrap modulo 2^32.
REQ-015 Row (a) SHALL hold indefinitely while dhit=0; state SHALL NOT advance during row (a), except that wb_halt=1 in HALT_DRAIN still moves to HALTED.
REQ-016 Simultaneous ex_branch_taken and id_halt SHALL squash the HALT and keep the FSM in RUN.

Reset
REQ-017 While nRST=0 at a rising edge: state<=RUN, halt<=0, cycle_count<=0, stall_count<=0.
REQ-018 Reset SHALL take effect from any state, including HALTED and mid-freeze.
REQ-019 During reset cycles, the outputs SHALL be the RUN decode of the current inputs after the first reset edge.

Verification
REQ-020 Reset, then ihit=1 and all other inputs 0 for 10 cycles -> all *_en=1, all *_zero=0, cycle_count=10, stall_count=0.
REQ-021 ex_dmemREN=1, ex_wsel=5, id_rt=5, ihit=1 for one cycle -> pc_en=0, fd_en=0, de_zero=1, stall_count +1; with ex_wsel=0 instead -> no stall.
REQ-022 mem_dreq=1, dhit=0 for 3 cycles with ex_branch_taken=1 -> all *_en=0 for 3 cycles and stall_count +3; the following dhit=1 cycle -> row (b).
REQ-023 id_jump=1 and ihit=0 together -> pc_en=1, fd_zero=1, stall_count unchanged.
REQ-024 id_halt=1 -> HALT_DRAIN next cycle with pc_en=0 and fd_zero=1; wb_halt=1 two cycles later -> halt=1, all *_en=0, counters frozen; nRST=0 -> halt=0, counters 0.
REQ-025 Preload cycle_count to 0xFFFFFFFF via forced state, then one RUN cycle -> cycle_count=0.
